// File: rtl/pll_supervisor.sv
// pll_supervisor: sequences a PLL through reset, lock acquisition and lock
// stabilisation, then releases downstream reset. A lock timeout causes a
// retry, and too many retries park the block in FAIL. A lock loss in RUN
// restarts the sequence and is counted.
//
// Ports:
//   clk            single clock for all logic
//   rst            asynchronous active-high reset
//   pll_lock       PLL LOCK, asynchronous to clk (synchronised internally)
//   req_restart    single-cycle request to restart the sequence
//   pll_reset_n    PLL RESETB, active-low
//   rst_out        downstream reset, active-high (low only in RUN)
//   ready          high only in RUN
//   fail           high only in FAIL
//   state          0=RESET_PLL 1=WAIT_LOCK 2=STABILIZE 3=RUN 4=FAIL
//   retry_cnt      lock timeouts since the last restart
//   lock_loss_cnt  lock losses seen in RUN, saturating at 255
module pll_supervisor #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 4096,
    parameter int unsigned STABLE_CYCLES  = 256,
    parameter int unsigned RETRY_MAX      = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       req_restart,
    output logic       pll_reset_n,
    output logic       rst_out,
    output logic       ready,
    output logic       fail,
    output logic [2:0] state,
    output logic [2:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam int unsigned TIMER_W = 16;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [TIMER_W-1:0]   timer_q;
    logic [TIMER_W-1:0]   timer_d;
    logic [2:0]           retry_d;
    logic [2:0]           retry_inc;
    logic [7:0]           loss_d;
    logic                 lock_m;
    logic                 lock_s;

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    // Next-state, timer and counter logic
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        retry_d   = retry_cnt;
        loss_d    = lock_loss_cnt;
        retry_inc = retry_cnt + 3'd1;

        if (req_restart) begin
            // Restart wins over any lock event seen in the same cycle
            state_d = ST_RESET_PLL;
            retry_d = 3'd0;
        end else begin
            case (state_q)
                ST_RESET_PLL: begin
                    if (timer_q == TIMER_W'(PLL_RST_CYCLES - 1))
                        state_d = ST_WAIT_LOCK;
                    else
                        timer_d = timer_q + 16'd1;
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABILIZE;
                    end else if (timer_q == TIMER_W'(LOCK_TIMEOUT - 1)) begin
                        retry_d = retry_inc;
                        state_d = (retry_inc == 3'(RETRY_MAX)) ? ST_FAIL : ST_RESET_PLL;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
                ST_STABILIZE: begin
                    // A lock drop takes priority over completing the count
                    if (!lock_s)
                        state_d = ST_WAIT_LOCK;
                    else if (timer_q == TIMER_W'(STABLE_CYCLES - 1))
                        state_d = ST_RUN;
                    else
                        timer_d = timer_q + 16'd1;
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        if (lock_loss_cnt != 8'hFF)
                            loss_d = lock_loss_cnt + 8'd1;
                        retry_d = 3'd0;
                        state_d = ST_RESET_PLL;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_RESET_PLL;
                end
            endcase
        end

        // Every state entry (including a restart into RESET_PLL) starts a fresh timer
        if (req_restart || (state_d != state_q))
            timer_d = '0;
    end

    // State, counters and outputs all update on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RESET_PLL;
            timer_q       <= '0;
            retry_cnt     <= 3'd0;
            lock_loss_cnt <= 8'd0;
            pll_reset_n   <= 1'b0;
            rst_out       <= 1'b1;
            ready         <= 1'b0;
            fail          <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            retry_cnt     <= retry_d;
            lock_loss_cnt <= loss_d;
            pll_reset_n   <= (state_d == ST_WAIT_LOCK) || (state_d == ST_STABILIZE) ||
                             (state_d == ST_RUN);
            rst_out       <= (state_d != ST_RUN);
            ready         <= (state_d == ST_RUN);
            fail          <= (state_d == ST_FAIL);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed testbench for pll_supervisor with small parameters:
// PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, RETRY_MAX=3.
// Inputs are driven and outputs sampled on the falling edge.
module tb_pll_supervisor;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       req_restart;
    logic       pll_reset_n;
    logic       rst_out;
    logic       ready;
    logic       fail;
    logic [2:0] state;
    logic [2:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pll_supervisor #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .RETRY_MAX     (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_lock     (pll_lock),
        .req_restart  (req_restart),
        .pll_reset_n  (pll_reset_n),
        .rst_out      (rst_out),
        .ready        (ready),
        .fail         (fail),
        .state        (state),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait (bounded) until RUN is reached
    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        logic [17:0] got;
        rst = 1'b1; pll_lock = 1'b0; req_restart = 1'b0;
        repeat (3) @(negedge clk);
        got = {state, pll_reset_n, rst_out, ready, fail, retry_cnt, lock_loss_cnt};
        n_checks++;
        if (got !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", got,
                     {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0});
        end
    endtask

    task automatic test_nominal();
        int low;
        int edges;
        rst = 1'b0;
        low = 0;
        do begin
            @(negedge clk);
            low++;
        end while (!pll_reset_n && low < 20);
        n_checks++;
        if (low !== 4) begin
            n_fail++;
            $display("FAIL nominal_reset_width: got %0d edges expected 4", low);
        end
        n_checks++;
        if (state !== 3'd1) begin
            n_fail++;
            $display("FAIL nominal_wait_state: got %0d expected 1", state);
        end
        repeat (9) @(negedge clk);
        pll_lock = 1'b1;
        edges = 0;
        do begin
            @(negedge clk);
            edges++;
        end while (!ready && edges < 40);
        // First sampling edge is index 1; RUN lands 10 edges later
        n_checks++;
        if (edges !== 11) begin
            n_fail++;
            $display("FAIL nominal_ready_latency: got edge %0d expected 11", edges);
        end
        n_checks++;
        if ({state, rst_out, pll_reset_n, retry_cnt} !== {3'd3, 1'b0, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL nominal_run_outputs: got state=%0d rst_out=%0b pll_reset_n=%0b retry=%0d expected 3 0 1 0",
                     state, rst_out, pll_reset_n, retry_cnt);
        end
    endtask

    task automatic test_loss();
        int edges;
        int low;
        pll_lock = 1'b0;
        edges = 0;
        do begin
            @(negedge clk);
            edges++;
        end while (ready && edges < 10);
        n_checks++;
        if (edges !== 3) begin
            n_fail++;
            $display("FAIL loss_detect_latency: got %0d edges expected 3", edges);
        end
        n_checks++;
        if ({rst_out, lock_loss_cnt, state, retry_cnt} !== {1'b1, 8'd1, 3'd0, 3'd0}) begin
            n_fail++;
            $display("FAIL loss_outputs: got rst_out=%0b loss=%0d state=%0d retry=%0d expected 1 1 0 0",
                     rst_out, lock_loss_cnt, state, retry_cnt);
        end
        pll_lock = 1'b1;
        low = 0;
        while (!pll_reset_n && low < 20) begin
            low++;
            @(negedge clk);
        end
        n_checks++;
        if (low !== 4) begin
            n_fail++;
            $display("FAIL loss_reset_width: got %0d expected 4", low);
        end
        wait_ready();
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL loss_relock: got ready=%0b expected 1", ready);
        end
    endtask

    task automatic test_restart_coincident();
        pll_lock = 1'b0;
        @(negedge clk);
        @(negedge clk);
        req_restart = 1'b1;
        @(negedge clk);
        req_restart = 1'b0;
        n_checks++;
        if ({state, lock_loss_cnt, ready} !== {3'd0, 8'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL restart_vs_loss: got state=%0d loss=%0d ready=%0b expected 0 1 0",
                     state, lock_loss_cnt, ready);
        end
        pll_lock = 1'b1;
        wait_ready();
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_relock: got ready=%0b expected 1", ready);
        end
    endtask

    task automatic test_glitch();
        int n;
        int edges;
        req_restart = 1'b1;
        @(negedge clk);
        req_restart = 1'b0;
        n = 0;
        while (state != 3'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (state !== 3'd2) begin
            n_fail++;
            $display("FAIL glitch_in_stabilize: got state=%0d expected 2", state);
        end
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        n = 0;
        while (state != 3'd1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if ({state, retry_cnt} !== {3'd1, 3'd0}) begin
            n_fail++;
            $display("FAIL glitch_back_to_wait: got state=%0d retry=%0d expected 1 0", state, retry_cnt);
        end
        // One edge back to STABILIZE, then a full fresh 8-cycle count
        edges = 0;
        do begin
            @(negedge clk);
            edges++;
        end while (!ready && edges < 40);
        n_checks++;
        if (edges !== 9) begin
            n_fail++;
            $display("FAIL glitch_count_restart: got %0d edges expected 9", edges);
        end
    endtask

    task automatic test_no_lock();
        int n0;
        int n1;
        int total;
        int rises;
        logic prev;
        pll_lock = 1'b0;
        req_restart = 1'b1;
        @(negedge clk);
        req_restart = 1'b0;
        n0 = 0; n1 = 0; total = 0; rises = 0;
        prev = pll_reset_n;
        while (!fail && total < 300) begin
            if (state == 3'd0) n0++;
            else if (state == 3'd1) n1++;
            @(negedge clk);
            total++;
            if (pll_reset_n && !prev) rises++;
            prev = pll_reset_n;
        end
        n_checks++;
        if (total !== 108) begin
            n_fail++;
            $display("FAIL nolock_time_to_fail: got %0d edges expected 108", total);
        end
        n_checks++;
        if (n0 !== 12 || n1 !== 96) begin
            n_fail++;
            $display("FAIL nolock_phase_cycles: got reset=%0d wait=%0d expected 12 96", n0, n1);
        end
        n_checks++;
        if (rises !== 3) begin
            n_fail++;
            $display("FAIL nolock_pulse_count: got %0d expected 3", rises);
        end
        n_checks++;
        if ({state, retry_cnt, pll_reset_n, rst_out} !== {3'd4, 3'd3, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL nolock_fail_outputs: got state=%0d retry=%0d pll_reset_n=%0b rst_out=%0b expected 4 3 0 1",
                     state, retry_cnt, pll_reset_n, rst_out);
        end
        repeat (50) @(negedge clk);
        n_checks++;
        if ({state, fail, pll_reset_n} !== {3'd4, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL nolock_fail_holds: got state=%0d fail=%0b pll_reset_n=%0b expected 4 1 0",
                     state, fail, pll_reset_n);
        end
    endtask

    task automatic test_restart_from_fail();
        pll_lock = 1'b1;
        req_restart = 1'b1;
        @(negedge clk);
        req_restart = 1'b0;
        n_checks++;
        if ({state, retry_cnt, fail, pll_reset_n} !== {3'd0, 3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL fail_restart: got state=%0d retry=%0d fail=%0b pll_reset_n=%0b expected 0 0 0 0",
                     state, retry_cnt, fail, pll_reset_n);
        end
        wait_ready();
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fail_restart_relock: got ready=%0b expected 1", ready);
        end
    endtask

    task automatic test_saturate();
        int timeouts = 0;
        int n;
        // One loss already recorded; 299 more make 300
        for (int i = 0; i < 299; i++) begin
            pll_lock = 1'b0;
            @(negedge clk);
            pll_lock = 1'b1;
            n = 0;
            while (ready && n < 10) begin
                @(negedge clk);
                n++;
            end
            if (ready) timeouts++;
            wait_ready();
            if (!ready) timeouts++;
        end
        n_checks++;
        if (lock_loss_cnt !== 8'd255 || timeouts !== 0) begin
            n_fail++;
            $display("FAIL loss_saturation: got loss=%0d timeouts=%0d expected 255 0", lock_loss_cnt, timeouts);
        end
    endtask

    task automatic test_async_reset();
        int n;
        logic [17:0] got;
        pll_lock = 1'b0;
        req_restart = 1'b1;
        @(negedge clk);
        req_restart = 1'b0;
        n = 0;
        while (state != 3'd1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({state, pll_reset_n} !== {3'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL async_precondition: got state=%0d pll_reset_n=%0b expected 1 1", state, pll_reset_n);
        end
        #2;
        rst = 1'b1;
        #1;
        got = {state, pll_reset_n, rst_out, ready, fail, retry_cnt, lock_loss_cnt};
        n_checks++;
        if (got !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL async_reset_values: got %h expected %h", got,
                     {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_loss();
        test_restart_coincident();
        test_glitch();
        test_no_lock();
        test_restart_from_fail();
        test_saturate();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
